// File: rtl/flappy_pkg.sv
// Shared Flappy definitions: screen geometry, bird size, FSM state codes
// and the saturating score increment.
// SCORE_BCD_EN selects a two-digit packed BCD score (0x00..0x99) instead
// of plain binary (0..255).
package flappy_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BIRD_SIZE = 16;

    // One-hot state codes, kept as plain constants so older blocks can share them
    localparam logic [2:0] S_IDLE   = 3'b001;
    localparam logic [2:0] S_SCROLL = 3'b010;
    localparam logic [2:0] S_HIT    = 3'b100;

    // Add one to the score, holding at the top value instead of wrapping
    function automatic logic [7:0] score_inc(input logic [7:0] s);
`ifdef SCORE_BCD_EN
        logic [7:0] r;
        if (s == 8'h99)
            r = s;
        else if (s[3:0] == 4'd9)
            r = {s[7:4] + 4'd1, 4'd0};
        else
            r = {s[7:4], s[3:0] + 4'd1};
        return r;
`else
        return (s == 8'hFF) ? s : s + 8'd1;
`endif
    endfunction

endpackage

// File: rtl/flappy_lfsr.sv
// 10-bit Fibonacci LFSR, polynomial x^10 + x^7 + 1.
// Free-running; 'load' puts the seed back synchronously.
module flappy_lfsr #(
    parameter logic [9:0] SEED = 10'h2A5
) (
    input  logic       Clk,
    input  logic       reset_n,
    input  logic       load,
    output logic [9:0] q
);

    // Shift left one place each clock, feeding q[9]^q[6] into bit 0
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)
            q <= SEED;
        else if (load)
            q <= SEED;
        else
            q <= {q[8:0], q[9] ^ q[6]};
    end

endmodule

// File: rtl/pipe_field.sv
// Flappy obstacle field: scrolls two pipes left, respawns them with
// pseudo-random gap heights, scores each pipe the bird clears and flags
// collisions with pipes, floor and ceiling.
// SCORE_BCD_EN (see flappy_pkg) switches Score to packed BCD.
module pipe_field
    import flappy_pkg::*;
#(
    parameter int         PIPE_W       = 40,
    parameter int         GAP_H        = 120,
    parameter int         GAP_MIN      = 80,
    parameter int         PIPE_SPACING = 320,
    parameter int         SCROLL_STEP  = 2,
    parameter logic [9:0] LFSR_SEED    = 10'h2A5
) (
    input  logic               Clk,
    input  logic               reset_n,
    input  logic               Tick,
    input  logic               Run,
    input  logic               Clear,
    input  logic signed [9:0]  Bird_X,
    input  logic signed [9:0]  Bird_Y,
    output logic signed [10:0] Pipe0_X,
    output logic [9:0]         Pipe0_GapY,
    output logic signed [10:0] Pipe1_X,
    output logic [9:0]         Pipe1_GapY,
    output logic               Hit,
    output logic [7:0]         Score
);

    // Geometry is compared in 12-bit signed so no sum can overflow
    localparam logic signed [11:0] PW_S    = 12'(PIPE_W);
    localparam logic signed [11:0] GH_S    = 12'(GAP_H);
    localparam logic signed [11:0] BS_S    = 12'(BIRD_SIZE);
    localparam logic signed [11:0] SH_S    = 12'(SCREEN_H);
    localparam logic signed [11:0] STEP_S  = 12'(SCROLL_STEP);
    localparam logic signed [11:0] WRAP_S  = 12'(2 * PIPE_SPACING);
    localparam logic signed [10:0] X0_INIT = 11'(SCREEN_W);
    localparam logic signed [10:0] X1_INIT = 11'(SCREEN_W + PIPE_SPACING);
    localparam logic [9:0]         GAP_INIT = 10'(GAP_MIN);

    logic [2:0]         state;
    logic               chk;
    logic [9:0]         lfsr_q;
    logic               passed0;
    logic               passed1;
    logic signed [11:0] bird_x;
    logic signed [11:0] bird_y;
    logic signed [11:0] move0;
    logic signed [11:0] move1;
    logic signed [10:0] next_x0;
    logic signed [10:0] next_x1;
    logic               respawn0;
    logic               respawn1;
    logic               pass0;
    logic               pass1;
    logic               collide;
    logic [9:0]         new_gap;
    logic [7:0]         score_next;

    // A pipe hits the bird when their x-ranges overlap and the bird box
    // is not wholly inside the opening
    function automatic logic pipe_hit(input logic signed [10:0] px,
                                      input logic [9:0]         gap,
                                      input logic signed [11:0] bx,
                                      input logic signed [11:0] by);
        logic signed [11:0] x;
        logic signed [11:0] top;
        x   = {px[10], px};
        top = $signed({2'b00, gap});
        return (bx < x + PW_S) && (x < bx + BS_S) &&
               !((by >= top) && (by + BS_S <= top + GH_S));
    endfunction

    flappy_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .Clk     (Clk),
        .reset_n (reset_n),
        .load    (Clear),
        .q       (lfsr_q)
    );

    // Next pipe positions, respawn/pass detection, score and collision tests
    always_comb begin
        bird_x   = {{2{Bird_X[9]}}, Bird_X};
        bird_y   = {{2{Bird_Y[9]}}, Bird_Y};
        move0    = {Pipe0_X[10], Pipe0_X} - STEP_S;
        move1    = {Pipe1_X[10], Pipe1_X} - STEP_S;
        respawn0 = (move0 + PW_S) <= 12'sd0;
        respawn1 = (move1 + PW_S) <= 12'sd0;
        next_x0  = respawn0 ? 11'(move0 + WRAP_S) : 11'(move0);
        next_x1  = respawn1 ? 11'(move1 + WRAP_S) : 11'(move1);
        pass0    = !passed0 && !respawn0 && (({next_x0[10], next_x0} + PW_S) < bird_x);
        pass1    = !passed1 && !respawn1 && (({next_x1[10], next_x1} + PW_S) < bird_x);
        new_gap  = GAP_INIT + (lfsr_q & 10'h07F);
        if (pass0 && pass1)
            score_next = score_inc(score_inc(Score));
        else if (pass0 || pass1)
            score_next = score_inc(Score);
        else
            score_next = Score;
        collide = pipe_hit(Pipe0_X, Pipe0_GapY, bird_x, bird_y) ||
                  pipe_hit(Pipe1_X, Pipe1_GapY, bird_x, bird_y) ||
                  (bird_y < 12'sd0) || (bird_y + BS_S > SH_S);
    end

    // The collision test runs the cycle after a Tick, on the moved pipes
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n)
            chk <= 1'b0;
        else
            chk <= Tick;
    end

    // Game FSM and pipe state; Clear re-initialises from any state
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            Pipe0_X    <= X0_INIT;
            Pipe1_X    <= X1_INIT;
            Pipe0_GapY <= GAP_INIT;
            Pipe1_GapY <= GAP_INIT;
            passed0    <= 1'b0;
            passed1    <= 1'b0;
            Score      <= 8'd0;
        end else if (Clear) begin
            state      <= S_IDLE;
            Pipe0_X    <= X0_INIT;
            Pipe1_X    <= X1_INIT;
            Pipe0_GapY <= GAP_INIT;
            Pipe1_GapY <= GAP_INIT;
            passed0    <= 1'b0;
            passed1    <= 1'b0;
            Score      <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Run)
                        state <= S_SCROLL;
                end
                S_SCROLL: begin
                    if (chk && collide)
                        state <= S_HIT;
                    if (Tick) begin
                        Pipe0_X <= next_x0;
                        Pipe1_X <= next_x1;
                        if (respawn0) begin
                            Pipe0_GapY <= new_gap;
                            passed0    <= 1'b0;
                        end else if (pass0) begin
                            passed0 <= 1'b1;
                        end
                        if (respawn1) begin
                            Pipe1_GapY <= new_gap;
                            passed1    <= 1'b0;
                        end else if (pass1) begin
                            passed1 <= 1'b1;
                        end
                        Score <= score_next;
                    end
                end
                S_HIT: begin
                    state <= S_HIT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign Hit = (state == S_HIT);

endmodule

// File: tb/tb_pipe_field.sv
// Directed bench for pipe_field: scrolling, respawn, scoring, pipe and
// bound collisions, Clear, score saturation and asynchronous reset.
module tb_pipe_field;

`ifdef SCORE_BCD_EN
    localparam logic [7:0] SCORE_MAX = 8'h99;
`else
    localparam logic [7:0] SCORE_MAX = 8'hFF;
`endif

    logic               Clk = 1'b0;
    logic               reset_n;
    logic               Tick;
    logic               Run;
    logic               Clear;
    logic signed [9:0]  Bird_X;
    logic signed [9:0]  Bird_Y;
    logic signed [10:0] Pipe0_X;
    logic [9:0]         Pipe0_GapY;
    logic signed [10:0] Pipe1_X;
    logic [9:0]         Pipe1_GapY;
    logic               Hit;
    logic [7:0]         Score;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [9:0] lfsr_m;
    logic [9:0] exp_gap;
    logic       hit_seen;
    int         sat_cycles;

    pipe_field dut (
        .Clk        (Clk),
        .reset_n    (reset_n),
        .Tick       (Tick),
        .Run        (Run),
        .Clear      (Clear),
        .Bird_X     (Bird_X),
        .Bird_Y     (Bird_Y),
        .Pipe0_X    (Pipe0_X),
        .Pipe0_GapY (Pipe0_GapY),
        .Pipe1_X    (Pipe1_X),
        .Pipe1_GapY (Pipe1_GapY),
        .Hit        (Hit),
        .Score      (Score)
    );

    always #5 Clk = ~Clk;

    // Reference LFSR: x^10+x^7+1 from seed 0x2A5, reseeded by reset and Clear
    always @(posedge Clk or negedge reset_n) begin
        if (!reset_n)
            lfsr_m <= 10'h2A5;
        else if (Clear)
            lfsr_m <= 10'h2A5;
        else
            lfsr_m <= {lfsr_m[8:0], lfsr_m[9] ^ lfsr_m[6]};
    end

    task automatic checkOutput(input string tag,
                               input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One Tick with the given bird position, then let the collision check cycle finish
    task automatic applyStimulus(input logic signed [9:0] bx, input logic signed [9:0] by);
        Bird_X = bx;
        Bird_Y = by;
        Tick   = 1'b1;
        @(negedge Clk);
        Tick   = 1'b0;
        @(negedge Clk);
    endtask

    task automatic clearPulse();
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
    endtask

    task automatic checkIdleValues(input string tag);
        checkOutput({tag, "_p0x"}, Pipe0_X, 640);
        checkOutput({tag, "_p1x"}, Pipe1_X, 960);
        checkOutput({tag, "_p0gap"}, Pipe0_GapY, 80);
        checkOutput({tag, "_p1gap"}, Pipe1_GapY, 80);
        checkOutput({tag, "_hit"}, Hit, 0);
        checkOutput({tag, "_score"}, Score, 0);
    endtask

    // Park the bird one pixel right of a pipe at x<=470 so it scores it without
    // touching either pipe (they are always 320 px apart); else park off-field
    function automatic logic signed [9:0] birdFor(input int x0, input int x1);
        if (x0 <= 470)
            return 10'(x0 + 41);
        else if (x1 <= 470)
            return 10'(x1 + 41);
        else
            return 10'(-100);
    endfunction

    initial begin
        reset_n = 1'b0;
        Tick    = 1'b0;
        Run     = 1'b0;
        Clear   = 1'b0;
        Bird_X  = 10'sd100;
        Bird_Y  = 10'sd150;
        repeat (2) @(negedge Clk);
        checkIdleValues("reset");

        reset_n = 1'b1;
        Run     = 1'b1;
        @(negedge Clk);

        // Five ticks from reset; bird sits inside pipe 0's opening [80,200)
        repeat (5) applyStimulus(10'sd100, 10'sd150);
        checkOutput("t1_p0x", Pipe0_X, 630);
        checkOutput("t1_p1x", Pipe1_X, 950);
        checkOutput("t1_hit", Hit, 0);
        checkOutput("t1_score", Score, 0);

        // Right edge reaches 100 (not yet below Bird_X) after 290 ticks
        repeat (285) applyStimulus(10'sd100, 10'sd150);
        checkOutput("t3_edge_eq_p0x", Pipe0_X, 60);
        checkOutput("t3_edge_eq_score", Score, 0);
        applyStimulus(10'sd100, 10'sd150);
        checkOutput("t3_cross_p0x", Pipe0_X, 58);
        checkOutput("t3_cross_score", Score, 1);
        applyStimulus(10'sd100, 10'sd150);
        checkOutput("t3_once_score", Score, 1);
        checkOutput("t3_hit", Hit, 0);

        // Walk pipe 0 to the left edge, then respawn on tick 340
        repeat (47) applyStimulus(10'sd100, 10'sd150);
        checkOutput("t2_pre_p0x", Pipe0_X, -38);
        exp_gap = 10'd80 + {3'b000, lfsr_m[6:0]};
        applyStimulus(10'sd100, 10'sd150);
        checkOutput("t2_respawn_p0x", Pipe0_X, 600);
        checkOutput("t2_respawn_gap", Pipe0_GapY, exp_gap);
        checkOutput("t2_p1x", Pipe1_X, 280);
        checkOutput("t2_score", Score, 1);

        // Bird above pipe 1's opening while overlapping it: Hit two clocks after Tick
        Bird_X = 10'sd290;
        Bird_Y = 10'sd50;
        Tick   = 1'b1;
        @(negedge Clk);
        Tick   = 1'b0;
        checkOutput("t4_p1x", Pipe1_X, 278);
        checkOutput("t4_hit_1clk", Hit, 0);
        @(negedge Clk);
        checkOutput("t4_hit_2clk", Hit, 1);
        repeat (3) applyStimulus(10'sd290, 10'sd50);
        checkOutput("t4_freeze_p0x", Pipe0_X, 598);
        checkOutput("t4_freeze_p1x", Pipe1_X, 278);
        checkOutput("t4_freeze_score", Score, 1);
        checkOutput("t4_freeze_hit", Hit, 1);

        // Clear from HIT with Run low: idle values, Tick ignored in IDLE
        Run = 1'b0;
        clearPulse();
        checkIdleValues("t5_clear");
        @(negedge Clk);
        applyStimulus(-10'sd100, 10'sd464);
        checkOutput("t5_idle_tick_p0x", Pipe0_X, 640);
        Run = 1'b1;
        @(negedge Clk);
        applyStimulus(-10'sd100, 10'sd464);
        checkOutput("t5_resume_p0x", Pipe0_X, 638);
        checkOutput("t5_resume_p1x", Pipe1_X, 958);
        checkOutput("t5_floor_edge_hit", Hit, 0);
        Run = 1'b0;
        applyStimulus(-10'sd100, 10'sd464);
        checkOutput("t5_runlow_p0x", Pipe0_X, 636);
        applyStimulus(-10'sd100, 10'sd470);
        checkOutput("t5_floor_hit", Hit, 1);
        checkOutput("t5_floor_p0x", Pipe0_X, 634);

        // Ceiling: y=-1 hits, y=0 does not
        Run = 1'b1;
        clearPulse();
        @(negedge Clk);
        applyStimulus(-10'sd100, -10'sd1);
        checkOutput("t5_ceil_hit", Hit, 1);
        clearPulse();
        @(negedge Clk);
        applyStimulus(-10'sd100, 10'sd0);
        checkOutput("t5_ceil_edge_hit", Hit, 0);

        // Score saturation with Tick held high every clock
        clearPulse();
        @(negedge Clk);
        Bird_Y     = 10'sd150;
        Tick       = 1'b1;
        hit_seen   = 1'b0;
        sat_cycles = 0;
        while (Score !== SCORE_MAX && sat_cycles < 50000) begin
            Bird_X = birdFor(int'(Pipe0_X), int'(Pipe1_X));
            @(negedge Clk);
            sat_cycles++;
            if (Hit === 1'b1)
                hit_seen = 1'b1;
        end
        checkOutput("t6_sat_reach", Score, SCORE_MAX);
        repeat (700) begin
            Bird_X = birdFor(int'(Pipe0_X), int'(Pipe1_X));
            @(negedge Clk);
            if (Hit === 1'b1)
                hit_seen = 1'b1;
        end
        checkOutput("t6_sat_hold", Score, SCORE_MAX);
        checkOutput("t6_no_hit", hit_seen, 0);

        // Asynchronous reset between clock edges while scrolling
        #2 reset_n = 1'b0;
        #1;
        checkIdleValues("t6_async");
        Tick = 1'b0;
        #2 reset_n = 1'b1;
        @(negedge Clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
